// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states,
// requester ids and the supported read-latency bound.
package mem_arbiter_pkg;

  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_ARBITER_RR_EN selects round-robin; otherwise data beats fetch.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic    if_req,
  input  logic    d_req,
  input  req_id_t last_gnt,
  output req_id_t winner,
  output logic    win_vld
);

  assign win_vld = if_req | d_req;

`ifdef MEM_ARBITER_RR_EN
  // On contention the requester that was not served last goes next.
  always_comb begin
    winner = REQ_D;
    if (if_req && d_req) begin
      winner = (last_gnt == REQ_D) ? REQ_IF : REQ_D;
    end else if (if_req) begin
      winner = REQ_IF;
    end
  end
`else
  logic unused_last_gnt;
  assign unused_last_gnt = (last_gnt == REQ_D);

  always_comb begin
    winner = d_req ? REQ_D : REQ_IF;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store paths.
// Arbitration policy is set by MEM_ARBITER_RR_EN (see mem_arbiter_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              busy
);

  localparam int CNT_W = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  req_id_t           owner_q, last_gnt_q, winner;
  logic              win_vld;
  logic [3:0]        we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;
  logic              if_rvalid_q, d_rvalid_q;
  logic [31:0]       if_rdata_q, d_rdata_q;

  mem_arbiter_pick u_pick (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_gnt (last_gnt_q),
    .winner   (winner),
    .win_vld  (win_vld)
  );

  always_comb begin
    state_d = state_q;
    mem_en  = 1'b0;
    mem_we  = 4'd0;
    if_gnt  = 1'b0;
    d_gnt   = 1'b0;
    busy    = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = we_q;
        if_gnt  = (owner_q == REQ_IF);
        d_gnt   = (owner_q == REQ_D);
        state_d = (we_q != 4'd0) ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Everything is cleared on reset so a read cut short never responds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= REQ_D;
      last_gnt_q  <= REQ_D;
      we_q        <= 4'd0;
      cnt_q       <= '0;
      addr_q      <= '0;
      din_q       <= 32'd0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            owner_q    <= winner;
            last_gnt_q <= winner;
            if (winner == REQ_D) begin
              addr_q <= d_addr;
              we_q   <= d_we;
              din_q  <= d_wdata;
            end else begin
              addr_q <= if_addr;
              we_q   <= 4'd0;
            end
          end
        end
        S_ACCESS: begin
          cnt_q <= CNT_LOAD;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            if (owner_q == REQ_IF) begin
              if_rdata_q  <= mem_dout;
              if_rvalid_q <= 1'b1;
            end else begin
              d_rdata_q  <= mem_dout;
              d_rvalid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported instruction/data memory between the core's instruction-fetch path and its load/store path. It accepts one request at a time, drives the memory port, and waits out the fixed memory read latency. It then returns read data to the requester that was granted. It sits between the core state machine and the BRAM, so fetch and data accesses no longer need separate memory ports.

## Interface
- RD_LAT, default 1: memory read latency in cycles, from the edge that captures the address to the edge where `mem_dout` is valid; legal range 1..4.
- ADDR_W, default 32: byte-address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until `if_gnt`.
- if_addr  in  ADDR_W  fetch byte address; held stable while `if_req` is high.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: `if_rdata` is valid.
- if_rdata  out  32  fetch data; holds its value until the next fetch response.
- d_req  in  1  load/store request; held until `d_gnt`.
- d_addr  in  ADDR_W  data byte address.
- d_we  in  4  byte write enables; 0 means read.
- d_wdata  in  32  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse, reads only.
- d_rdata  out  32  load data; holds its value until the next data read response.
- mem_en  out  1  memory access strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  4  memory byte write enables.
- mem_din  out  32  memory write data.
- mem_dout  in  32  memory read data.
- busy  out  1  high whenever the FSM is not in S_IDLE.

## Operation
FSM states and transitions:
- S_IDLE:
  - No request: stay in S_IDLE.
  - Any request pending: select a winner, register its address, write enables and write data onto the memory port, and go to S_ACCESS.
- S_ACCESS (exactly one cycle):
  - `mem_en` = 1; `mem_we` = the winner's `d_we`, or 0 if the winner is fetch.
  - The winner's gnt is high for this cycle.
  - Incoming requests are ignored in this cycle.
  - Next state: S_IDLE if this is a write (`d_we` ≠ 0); otherwise S_WAIT with the counter loaded to RD_LAT.
- S_WAIT:
  - The counter decrements every cycle.
  - When the counter reaches 1: capture `mem_dout` into the owner's rdata, pulse the owner's rvalid in the next cycle, and go to S_IDLE.

Arbitration and data handling:
- When both requesters are pending, the winner is decided by the arbitration policy (see Configuration).
- The owner of an outstanding read is latched in S_IDLE; responses are never misrouted.
- Outside S_ACCESS: `mem_en` = 0 and `mem_we` = 0. `mem_addr` and `mem_din` hold their last values.
- Addresses pass through unchanged. No alignment check; byte lanes are the requester's responsibility.
- Dropping a req before its gnt is a protocol violation. A request already latched still completes.

Reset:
- Every output is 0 after reset, including both rdata registers.
- State returns to S_IDLE, `last_gnt` = data.
- On reset mid-transaction, the pending rvalid is never issued.

## Timing
- Request sampled at edge E0; gnt and `mem_en` are high in the cycle after E0.
- Reads: rvalid is high RD_LAT+1 cycles after the S_ACCESS cycle.
- Cycles per read: RD_LAT+2. Cycles per write: 2.
- The rvalid cycle is an S_IDLE cycle, so a new request can be sampled in that same cycle (back-to-back accesses).
- Requesters see gnt combinationally from a register and may drop req on the next edge.

## Configuration
- MEM_ARBITER_RR_EN defined: round-robin arbitration. On contention, the requester other than `last_gnt` wins; `last_gnt` updates on every grant.
- MEM_ARBITER_RR_EN undefined: fixed priority, data beats fetch. `last_gnt` is not implemented.

## Structure
- mem_arbiter_pkg:
  - `typedef enum` for states S_IDLE, S_ACCESS, S_WAIT.
  - `typedef enum` requester id: REQ_IF, REQ_D.
  - Localparam for the RD_LAT upper bound.
- Counter width: `$clog2(RD_LAT+1)`.
- One combinational sub-module, mem_arbiter_pick:
  - Inputs: `if_req`, `d_req`, `last_gnt`.
  - Output: winner id plus a valid flag.
  - Holds the only code that depends on MEM_ARBITER_RR_EN.

## Test plan
- Fetch read, RD_LAT=1, if_addr=0x10, memory returns 0x00000013 → if_gnt 1 cycle after req sampled; if_rvalid 2 cycles after gnt with if_rdata=0x00000013.
- Store d_addr=0x100, d_we=4'b1111, d_wdata=0xDEADBEEF → exactly one cycle with mem_en=1, mem_we=4'b1111; d_gnt pulses once; no d_rvalid.
- Both requesters high on the same edge, fixed priority → d granted first; fetch granted in the cycle after d_rvalid. With MEM_ARBITER_RR_EN, two contested rounds → grants alternate IF, D.
- RD_LAT=3 read of 0xCAFEF00D → rvalid 4 cycles after the S_ACCESS cycle; busy high from S_ACCESS until the cycle before rvalid.
- Assert rst during S_WAIT → all outputs 0 in the same cycle; no rvalid afterwards; the next request is served normally.
- Back-to-back data reads at 0x0 and 0x4 with req held high → second d_gnt in the cycle after the first d_rvalid; each rdata matches its address.
